life_window: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of the per-cell Life rule. It accepts one grid generation as a raster-order stream of 1-bit cells, buffers two rows plus three cells, and emits, for every cell, its own state and its eight neighbours in the bit order the rule stage consumes. Off-grid neighbours read as dead. Output order is the same raster order as the input, so the rule outputs can be written straight into the next-generation frame.

---
 rtl/life_pkg.sv | 29 ++
 rtl/life_line_buf.sv | 65 ++++++
 rtl/life_window.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_life_window.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg
// Shared definitions for the life_window neighbourhood generator:
//   - neighbour bit positions inside the 8-bit neighbour vector
//   - FSM state type of the window generator
//   - helper that sizes the live-cell counter for a W x H grid
package life_pkg;

  // Bit positions of each neighbour in out_n, in the order the rule stage reads them
  localparam int NB_NW = 0;
  localparam int NB_N  = 1;
  localparam int NB_NE = 2;
  localparam int NB_W  = 3;
  localparam int NB_E  = 4;
  localparam int NB_SW = 5;
  localparam int NB_S  = 6;
  localparam int NB_SE = 7;

  typedef enum logic [1:0] {
    FILL  = 2'd0,  // priming the line buffer, no output yet
    RUN   = 2'd1,  // one window per accepted cell
    FLUSH = 2'd2   // input closed, zeros pushed to drain the last W+1 windows
  } life_state_t;

  // Width needed to hold a live-cell count from 0 to w*h inclusive
  function automatic int pop_w(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/life_line_buf.sv
// life_line_buf
// Shift register of 2W+3 cells holding two full rows plus three cells of the
// raster stream. Newest cell sits at position 0.
//
// The taps are taken from the value the register will hold once din has
// shifted in, so the window that the incoming cell completes is available in
// the same cycle the cell is accepted and can be registered at that edge.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears the register
//   en     shift din in this cycle
//   clr    synchronous clear (wins over en), used at frame end
//   din    cell shifted in at position 0
//   taps   [0]=pos 0, [1]=1, [2]=2, [3]=W, [4]=W+1 (centre), [5]=W+2,
//          [6]=2W, [7]=2W+1, [8]=2W+2 of the post-shift value
module life_line_buf #(
  parameter int W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [8:0] taps
);

  localparam int L = 2 * W + 3;

  logic [L-1:0] sr_r;
  logic [L-1:0] sr_nxt_s;

  // Post-shift view of the register
  always_comb begin
    sr_nxt_s = {sr_r[L-2:0], din};
  end

  // Window taps from the post-shift view
  always_comb begin
    taps    = 9'b0;
    taps[0] = sr_nxt_s[0];
    taps[1] = sr_nxt_s[1];
    taps[2] = sr_nxt_s[2];
    taps[3] = sr_nxt_s[W];
    taps[4] = sr_nxt_s[W + 1];
    taps[5] = sr_nxt_s[W + 2];
    taps[6] = sr_nxt_s[2 * W];
    taps[7] = sr_nxt_s[2 * W + 1];
    taps[8] = sr_nxt_s[2 * W + 2];
  end

  // Storage register with reset, clear and shift enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_r <= {L{1'b0}};
    end else if (clr) begin
      sr_r <= {L{1'b0}};
    end else if (en) begin
      sr_r <= sr_nxt_s;
    end else begin
      sr_r <= sr_r;
    end
  end

endmodule

// File: rtl/life_window.sv
// life_window
// Streaming 3x3 neighbourhood generator for a W x H Game-of-Life grid.
// Takes one generation as a raster-order stream of cells and emits, in the
// same raster order, each cell's own state and its eight neighbours.
// Neighbours outside the grid read as dead.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_cell is valid
//   in_ready   cell accepted this cycle when in_valid is also high
//   in_cell    cell state, row 0 col 0 first
//   out_valid  window valid
//   out_ready  downstream takes the window
//   out_self   centre cell
//   out_n      neighbours [0]NW [1]N [2]NE [3]W [4]E [5]SW [6]S [7]SE
//   out_last   window belongs to cell (H-1, W-1)
//   pop_count  live cells in the last completed input frame
//              (present only when LIFE_WINDOW_STATS_EN is defined)
//
// Optional feature macro: LIFE_WINDOW_STATS_EN (live-cell counter).
module life_window
  import life_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cell,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_self,
  output logic [7:0] out_n,
  output logic       out_last
`ifdef LIFE_WINDOW_STATS_EN
  ,
  output logic [pop_w(W, H)-1:0] pop_count
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  life_state_t   state_r;
  life_state_t   state_nxt_s;

  logic [CW-1:0] in_col_r;
  logic [RW-1:0] in_row_r;
  logic [CW-1:0] ctr_col_r;
  logic [RW-1:0] ctr_row_r;

  logic          out_free_s;
  logic          in_fire_s;
  logic          in_last_s;
  logic          ctr_last_s;
  logic          flush_go_s;
  logic          emit_s;
  logic          shift_s;
  logic          frame_done_s;
  logic          lb_din_s;
  logic [8:0]    taps_s;
  logic [7:0]    nb_raw_s;
  logic [7:0]    nb_mask_s;

  // Output slot is free when empty or being drained this cycle
  always_comb begin
    out_free_s = !out_valid || out_ready;
  end

  // Input handshake; held off during reset and while draining the frame
  always_comb begin
    in_ready  = rst_n && (state_r != FLUSH) && out_free_s;
    in_fire_s = in_valid && in_ready;
  end

  // Frame position decodes and datapath controls
  always_comb begin
    in_last_s    = (in_row_r == ROW_LAST) && (in_col_r == COL_LAST);
    ctr_last_s   = (ctr_row_r == ROW_LAST) && (ctr_col_r == COL_LAST);
    flush_go_s   = rst_n && (state_r == FLUSH) && out_free_s;
    emit_s       = ((state_r == RUN) && in_fire_s) || flush_go_s;
    shift_s      = in_fire_s || flush_go_s;
    frame_done_s = flush_go_s && ctr_last_s;
  end

  // During the drain the register is fed dead cells
  always_comb begin
    if (state_r == FLUSH) begin
      lb_din_s = 1'b0;
    end else begin
      lb_din_s = in_cell;
    end
  end

  life_line_buf #(
    .W(W)
  ) u_line_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (shift_s),
    .clr  (frame_done_s),
    .din  (lb_din_s),
    .taps (taps_s)
  );

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        // Cell index W is (row 1, col 0); once it is in, the next cell
        // completes the window of cell 0.
        if (in_fire_s && (in_row_r == RW'(1'b1)) && (in_col_r == {CW{1'b0}})) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FILL;
        end
      end
      RUN: begin
        if (in_fire_s && in_last_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (frame_done_s) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = FILL;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Input raster counters; wrap to (0,0) after the last cell of a frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_col_r <= {CW{1'b0}};
      in_row_r <= {RW{1'b0}};
    end else if (in_fire_s) begin
      if (in_col_r == COL_LAST) begin
        in_col_r <= {CW{1'b0}};
        if (in_row_r == ROW_LAST) begin
          in_row_r <= {RW{1'b0}};
        end else begin
          in_row_r <= in_row_r + RW'(1'b1);
        end
      end else begin
        in_col_r <= in_col_r + CW'(1'b1);
        in_row_r <= in_row_r;
      end
    end else begin
      in_col_r <= in_col_r;
      in_row_r <= in_row_r;
    end
  end

  // Centre counters; advance once per window emitted, trailing input by W+1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr_col_r <= {CW{1'b0}};
      ctr_row_r <= {RW{1'b0}};
    end else if (emit_s) begin
      if (ctr_col_r == COL_LAST) begin
        ctr_col_r <= {CW{1'b0}};
        if (ctr_row_r == ROW_LAST) begin
          ctr_row_r <= {RW{1'b0}};
        end else begin
          ctr_row_r <= ctr_row_r + RW'(1'b1);
        end
      end else begin
        ctr_col_r <= ctr_col_r + CW'(1'b1);
        ctr_row_r <= ctr_row_r;
      end
    end else begin
      ctr_col_r <= ctr_col_r;
      ctr_row_r <= ctr_row_r;
    end
  end

  // Map shift-register taps to compass neighbours of the centre at tap W+1
  always_comb begin
    nb_raw_s        = 8'b0;
    nb_raw_s[NB_SE] = taps_s[0];
    nb_raw_s[NB_S]  = taps_s[1];
    nb_raw_s[NB_SW] = taps_s[2];
    nb_raw_s[NB_E]  = taps_s[3];
    nb_raw_s[NB_W]  = taps_s[5];
    nb_raw_s[NB_NE] = taps_s[6];
    nb_raw_s[NB_N]  = taps_s[7];
    nb_raw_s[NB_NW] = taps_s[8];
  end

  // Border mask: kills off-grid neighbours, including cells of the adjacent
  // row that sit next to the centre in the register across a row wrap
  always_comb begin
    nb_mask_s = 8'hFF;
    if (ctr_row_r == {RW{1'b0}}) begin
      nb_mask_s[NB_NW] = 1'b0;
      nb_mask_s[NB_N]  = 1'b0;
      nb_mask_s[NB_NE] = 1'b0;
    end else begin
      nb_mask_s = nb_mask_s;
    end
    if (ctr_row_r == ROW_LAST) begin
      nb_mask_s[NB_SW] = 1'b0;
      nb_mask_s[NB_S]  = 1'b0;
      nb_mask_s[NB_SE] = 1'b0;
    end else begin
      nb_mask_s = nb_mask_s;
    end
    if (ctr_col_r == {CW{1'b0}}) begin
      nb_mask_s[NB_NW] = 1'b0;
      nb_mask_s[NB_W]  = 1'b0;
      nb_mask_s[NB_SW] = 1'b0;
    end else begin
      nb_mask_s = nb_mask_s;
    end
    if (ctr_col_r == COL_LAST) begin
      nb_mask_s[NB_NE] = 1'b0;
      nb_mask_s[NB_E]  = 1'b0;
      nb_mask_s[NB_SE] = 1'b0;
    end else begin
      nb_mask_s = nb_mask_s;
    end
  end

  // Output register: load a new window, drop valid on transfer, else hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_self  <= 1'b0;
      out_n     <= 8'b0;
      out_last  <= 1'b0;
    end else if (emit_s) begin
      out_valid <= 1'b1;
      out_self  <= taps_s[4];
      out_n     <= nb_raw_s & nb_mask_s;
      out_last  <= ctr_last_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_self  <= out_self;
      out_n     <= out_n;
      out_last  <= out_last;
    end else begin
      out_valid <= out_valid;
      out_self  <= out_self;
      out_n     <= out_n;
      out_last  <= out_last;
    end
  end

`ifdef LIFE_WINDOW_STATS_EN
  localparam int PW = pop_w(W, H);

  logic [PW-1:0] live_acc_r;
  logic [PW-1:0] live_inc_s;

  // Increment contributed by the cell being accepted
  always_comb begin
    live_inc_s = {{(PW-1){1'b0}}, in_cell};
  end

  // Live-cell accumulator; result published when the frame's last cell lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_acc_r <= {PW{1'b0}};
      pop_count  <= {PW{1'b0}};
    end else if (in_fire_s && in_last_s) begin
      live_acc_r <= {PW{1'b0}};
      pop_count  <= live_acc_r + live_inc_s;
    end else if (in_fire_s) begin
      live_acc_r <= live_acc_r + live_inc_s;
      pop_count  <= pop_count;
    end else begin
      live_acc_r <= live_acc_r;
      pop_count  <= pop_count;
    end
  end
`endif

endmodule

// File: tb/tb_life_window.sv
// Scoreboard bench for life_window on a 4x3 grid. Stimulus pushes the
// expected window stream into a queue; the monitor pops and compares on every
// output transfer and checks stalled outputs against the pending entry.
module tb_life_window;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int PW = $clog2(W * H + 1);

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_cell;
  logic       out_valid;
  logic       out_ready;
  logic       out_self;
  logic [7:0] out_n;
  logic       out_last;
`ifdef LIFE_WINDOW_STATS_EN
  logic [PW-1:0] pop_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] exp_q[$];        // {last, self, n}
  logic [7:0] rx_n[0:N-1];
  logic       rx_self[0:N-1];
  int         rx_idx = 0;
  bit         stall_en = 1'b0;

  life_window #(.W(W), .H(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cell  (in_cell),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_self (out_self),
    .out_n    (out_n),
    .out_last (out_last)
`ifdef LIFE_WINDOW_STATS_EN
    ,
    .pop_count(pop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cell_at(input logic [N-1:0] f, input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
    return f[r * W + c];
  endfunction

  // Reference window from a 2-D view of the frame
  function automatic logic [9:0] model(input logic [N-1:0] f, input int idx);
    int r, c;
    logic [7:0] n;
    r = idx / W;
    c = idx % W;
    n[0] = cell_at(f, r - 1, c - 1);
    n[1] = cell_at(f, r - 1, c);
    n[2] = cell_at(f, r - 1, c + 1);
    n[3] = cell_at(f, r, c - 1);
    n[4] = cell_at(f, r, c + 1);
    n[5] = cell_at(f, r + 1, c - 1);
    n[6] = cell_at(f, r + 1, c);
    n[7] = cell_at(f, r + 1, c + 1);
    return {(idx == N - 1), f[idx], n};
  endfunction

  // Downstream readiness, changed just after each rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every transfer, and stalled outputs against the head entry
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        vectors++;
        $display("FAIL unexpected_window: got 0x%0h, expected none", {out_last, out_self, out_n});
      end else begin
        check("window", {22'd0, out_last, out_self, out_n}, {22'd0, exp_q.pop_front()});
        rx_n[rx_idx]    = out_n;
        rx_self[rx_idx] = out_self;
        rx_idx          = (rx_idx + 1) % N;
      end
    end else if (out_valid && !out_ready && exp_q.size() != 0) begin
      check("stall_hold", {22'd0, out_last, out_self, out_n}, {22'd0, exp_q[0]});
    end
  end

  // Push the expected windows, then stream ncells cells of the frame
  task automatic drive_frame(input logic [N-1:0] f, input int ncells);
    int t;
    int nwin;
    nwin = (ncells >= N) ? N : ((ncells > W + 1) ? ncells - W - 1 : 0);
    for (int i = 0; i < nwin; i++) exp_q.push_back(model(f, i));
    for (int i = 0; i < ncells; i++) begin
      in_valid = 1'b1;
      in_cell  = f[i];
      t = 0;
      while (!in_ready && t < 2000) begin
        @(posedge clk);
        #3;
        t++;
      end
      if (t >= 2000) begin
        miscompares++;
        $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 2000 cycles");
      end
      @(posedge clk);
      #3;
    end
    in_valid = 1'b0;
    in_cell  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #3;
      t++;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d windows pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) begin
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_cell  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_n", out_n, 8'h00);
    check("rst_out_self", out_self, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
`ifdef LIFE_WINDOW_STATS_EN
    check("rst_pop_count", pop_count, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #3;

    // All-zero frame, then count the flush cycles with input closed
    drive_frame(12'h000, N);
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      if (in_ready) break;
      cnt++;
      @(posedge clk);
      #3;
    end
    check("flush_cycles", cnt, 5);
    wait_drain();

    // Single live cell at (1,1)
    rx_idx = 0;
    drive_frame(12'h020, N);
    wait_drain();
    check("single_00_n", rx_n[0], 8'h80);
    check("single_11_self", rx_self[5], 1'b1);
    check("single_11_n", rx_n[5], 8'h00);
    check("single_22_n", rx_n[10], 8'h01);

    // All-ones frame: corners, edges, centre and the row seam
    drive_frame(12'hFFF, N);
    wait_drain();
    check("ones_00_n", rx_n[0], 8'hD0);
    check("ones_01_n", rx_n[1], 8'hF8);
    check("ones_11_n", rx_n[5], 8'hFF);
    check("ones_03_seam_n", rx_n[3], 8'h68);
    check("ones_10_seam_n", rx_n[4], 8'hD6);

    // Same pattern unstalled and with random backpressure
    drive_frame(12'hA5C, N);
    wait_drain();
    stall_en = 1'b1;
    drive_frame(12'hA5C, N);
    drive_frame(12'h3C6, N);
    wait_drain();
    stall_en = 1'b0;
    @(posedge clk);
    #3;

    // Back-to-back frames
    drive_frame(12'h5A1, N);
    drive_frame(12'h9E7, N);
    wait_drain();

    // Reset mid-frame while a window is being presented
    drive_frame(12'hFFF, 7);
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_n", out_n, 8'h00);
    check("mid_rst_out_self", out_self, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_pending", exp_q.size(), 0);
    exp_q.delete();
    rst_n  = 1'b1;
    rx_idx = 0;
    @(posedge clk);
    #3;
    drive_frame(12'h6B2, N);
    wait_drain();

`ifdef LIFE_WINDOW_STATS_EN
    // Live-cell count: 5 live, then 0 live
    drive_frame(12'h0A7, N);
    check("pop_count_5", pop_count, 5);
    wait_drain();
    check("pop_count_hold", pop_count, 5);
    drive_frame(12'h000, N);
    check("pop_count_0", pop_count, 0);
    wait_drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
